// File: rtl/vga_pkg.sv
// Shared VGA/logo constants: scroll FSM state encoding, coordinate width, logo origin.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package vga_pkg;

   localparam int COORD_W = 11;
   localparam int LOGO_X0 = 500;
   localparam int LOGO_Y0 = 550;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RIGHT  = 3'd1,
      ST_HOLD_R = 3'd2,
      ST_LEFT   = 3'd3,
      ST_HOLD_L = 3'd4
   } scroll_state_e;

   // Paint-side X of logo column k for offset delt. 11-bit arithmetic; MAX_DELT
   // is picked by the integrator so that this never wraps.
   function automatic logic [COORD_W-1:0] logo_x(input logic [COORD_W-1:0] delt,
                                                 input logic [COORD_W-1:0] k);
      return COORD_W'(LOGO_X0) + delt + k;
   endfunction

   // Paint-side Y of logo row r; the logo never moves vertically.
   function automatic logic [COORD_W-1:0] logo_y(input logic [COORD_W-1:0] r);
      return COORD_W'(LOGO_Y0) + r;
   endfunction

endpackage

// File: rtl/logo_scroll_ctrl_if.sv
// Bundle between sync generator / host and the logo scroll controller.
// Latency: n/a (wires only).
// Backpressure: none; vsync/enable are level signals, outputs are registered levels/pulses.
// Signals: enable, vsync (to controller); delt, dir, moving, turn (from controller).
interface logo_scroll_ctrl_if;
   import vga_pkg::*;

   logic               enable;
   logic               vsync;
   logic [COORD_W-1:0] delt;
   logic               dir;
   logic               moving;
   logic               turn;

   modport master (output enable, output vsync,
                   input  delt, input dir, input moving, input turn);
   modport slave  (input  enable, input vsync,
                   output delt, output dir, output moving, output turn);

endinterface

// File: rtl/frame_tick_gen.sv
// Frame tick from vsync rising edge, plus a divide-by-FRAMES_PER_STEP step strobe.
// Latency: tick/step are combinational from vsync and one registered vsync sample.
// Backpressure: none; clear zeroes the divider and wins over a same-cycle tick.
// Ports: clk, rst, vsync, clear in; tick, step out.
module frame_tick_gen #(
   parameter int FRAMES_PER_STEP = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic vsync,
   input  logic clear,
   output logic tick,
   output logic step
);

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   logic             vs_d_q,  vs_d_d;
   logic             armed_q, armed_d;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   // armed_q masks the first cycle after reset: vs_d resets low, so a vsync
   // already high at release would otherwise look like a rising edge.
   assign tick = vsync & ~vs_d_q & armed_q;
   assign step = tick & (frame_cnt_q == CNT_LAST);

   always_comb begin
      vs_d_d      = vsync;
      armed_d     = 1'b1;
      frame_cnt_d = frame_cnt_q;
      if (clear) begin
         frame_cnt_d = '0;
      end else if (step) begin
         frame_cnt_d = '0;
      end else if (tick) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vs_d_q      <= 1'b0;
         armed_q     <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         vs_d_q      <= vs_d_d;
         armed_q     <= armed_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

endmodule

// File: rtl/logo_scroll_ctrl.sv
// Bouncing logo X offset: steps delt between 0 and MAX_DELT, pausing at each end.
// Latency: delt/dir/turn update on the clk edge that samples the vsync rising edge.
// Backpressure: none; enable low freezes delt/dir and parks the FSM in IDLE next clk.
// Ports: clk, rst (async, active high); bus.slave: enable, vsync in; delt, dir, moving, turn out.
module logo_scroll_ctrl
   import vga_pkg::*;
#(
   parameter int MAX_DELT        = 200,
   parameter int STEP            = 4,
   parameter int FRAMES_PER_STEP = 2,
   parameter int PAUSE_FRAMES    = 30
) (
   input  logic             clk,
   input  logic             rst,
   logo_scroll_ctrl_if.slave bus
);

   localparam int PAUSE_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
   localparam logic [PAUSE_W-1:0] PAUSE_LAST = PAUSE_W'(PAUSE_FRAMES - 1);
   localparam logic [COORD_W:0]   MAX_X      = (COORD_W + 1)'(MAX_DELT);
   localparam logic [COORD_W:0]   STEP_X     = (COORD_W + 1)'(STEP);
   localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);

   scroll_state_e      state_q, state_d;
   logic [COORD_W-1:0] delt_q, delt_d;
   logic               dir_q, dir_d;
   logic               moving_q, moving_d;
   logic               turn_q, turn_d;
   logic [PAUSE_W-1:0] pause_cnt_q, pause_cnt_d;

   logic               tick;
   logic               step;
   logic               div_clear;
   logic [COORD_W:0]   nxt_up;

   frame_tick_gen #(
      .FRAMES_PER_STEP(FRAMES_PER_STEP)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .vsync(bus.vsync),
      .clear(div_clear),
      .tick (tick),
      .step (step)
   );

   // One extra bit so the end-stop compare sees an overshoot instead of a wrap.
   assign nxt_up = {1'b0, delt_q} + STEP_X;

   always_comb begin
      state_d     = state_q;
      delt_d      = delt_q;
      dir_d       = dir_q;
      turn_d      = 1'b0;
      pause_cnt_d = pause_cnt_q;
      div_clear   = 1'b0;

      // Disable takes priority over everything, including a same-cycle step.
      if (!bus.enable) begin
         state_d     = ST_IDLE;
         pause_cnt_d = '0;
         div_clear   = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = dir_q ? ST_LEFT : ST_RIGHT;
            end
            ST_RIGHT: begin
               if (step) begin
                  if (nxt_up >= MAX_X) begin
                     delt_d      = MAX_X[COORD_W-1:0];
                     turn_d      = 1'b1;
                     dir_d       = 1'b1;
                     pause_cnt_d = '0;
                     state_d     = (PAUSE_FRAMES == 0) ? ST_LEFT : ST_HOLD_R;
                  end else begin
                     delt_d = nxt_up[COORD_W-1:0];
                  end
               end
            end
            ST_LEFT: begin
               if (step) begin
                  if (delt_q <= STEP_C) begin
                     delt_d      = '0;
                     turn_d      = 1'b1;
                     dir_d       = 1'b0;
                     pause_cnt_d = '0;
                     state_d     = (PAUSE_FRAMES == 0) ? ST_RIGHT : ST_HOLD_L;
                  end else begin
                     delt_d = delt_q - STEP_C;
                  end
               end
            end
            ST_HOLD_R, ST_HOLD_L: begin
               if (tick) begin
                  if (pause_cnt_q == PAUSE_LAST) begin
                     // Restart the divider so the first move after a pause
                     // takes a full FRAMES_PER_STEP frames.
                     pause_cnt_d = '0;
                     div_clear   = 1'b1;
                     state_d     = (state_q == ST_HOLD_R) ? ST_LEFT : ST_RIGHT;
                  end else begin
                     pause_cnt_d = pause_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Registered alongside state_q so moving always matches the live state.
      moving_d = (state_d == ST_RIGHT) || (state_d == ST_LEFT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         delt_q      <= '0;
         dir_q       <= 1'b0;
         moving_q    <= 1'b0;
         turn_q      <= 1'b0;
         pause_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         delt_q      <= delt_d;
         dir_q       <= dir_d;
         moving_q    <= moving_d;
         turn_q      <= turn_d;
         pause_cnt_q <= pause_cnt_d;
      end
   end

   assign bus.delt   = delt_q;
   assign bus.dir    = dir_q;
   assign bus.moving = moving_q;
   assign bus.turn   = turn_q;

endmodule
